// File: rtl/score_pkg.sv
// Shared types and sizing for the score display scheduler.
// Converter helpers live here so the BCD engine stays small.
package score_pkg;

    localparam int SCORE_W_DEF    = 20;
    localparam int DIGITS_DEF     = 6;
    localparam int BCD_INT_DIGITS = 7;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        CONV,
        HOLD
    } sched_state_e;

    function automatic bcd_t add3(input bcd_t d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle, done pulses with bcd final.
// The first shift happens on the start edge (nothing to adjust yet).
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [SCORE_W-1:0]            bin,
    output logic                          done,
    output logic [BCD_INT_DIGITS*4-1:0]   bcd
);

    localparam int BW = BCD_INT_DIGITS * 4;
    localparam int CW = $clog2(SCORE_W + 1);
    localparam logic [CW-1:0] LAST = CW'(SCORE_W - 1);

    logic [SCORE_W-1:0] shreg;
    logic [CW-1:0]      cnt;
    logic               running;
    logic [BW-1:0]      adj;

    always_comb begin
        adj = '0;
        for (int i = 0; i < BCD_INT_DIGITS; i++) begin
            adj[i*4 +: 4] = add3(bcd[i*4 +: 4]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bcd     <= {{(BW-1){1'b0}}, bin[SCORE_W-1]};
                shreg   <= bin << 1;
                cnt     <= CW'(1);
                running <= 1'b1;
            end else if (running) begin
                {bcd, shreg} <= {adj, shreg} << 1;
                if (cnt == LAST) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/score_display_sched.sv
// Round-robin score readout scheduler: arbitrate, convert to BCD, dwell.
// Display registers (digits/overflow/sel) only move on the commit edge.
module score_display_sched
    import score_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int SCORE_W     = SCORE_W_DEF,
    parameter int DIGITS      = DIGITS_DEF,
    parameter int HOLD_CYCLES = 50000000,
    localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*SCORE_W-1:0] value,
    output logic [NUM_REQ-1:0]         grant,
    output logic [SW-1:0]              sel,
    output logic [DIGITS*4-1:0]        digits,
    output logic                       digits_valid,
    output logic                       overflow,
    output logic                       busy
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam int BW = BCD_INT_DIGITS * 4;

    sched_state_e state, state_nx;

    logic [SW-1:0]       ptr;
    logic [SW-1:0]       pick;
    logic                found;
    logic                start;
    logic                conv_done;
    logic [SCORE_W-1:0]  bin;
    logic [BW-1:0]       bcd;
    logic [HW-1:0]       hold_cnt;
    logic                hold_last;
    logic [DIGITS*4-1:0] sat_digits;
    logic                sat;
    int                  idx;

    // search starts just after the last granted source and wraps
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = SW'(idx);
            end
        end
    end

    assign start     = (state == ARB) && found;
    assign bin       = value[int'(pick)*SCORE_W +: SCORE_W];
    assign hold_last = (hold_cnt == HOLD_LAST);
    assign busy      = (state != IDLE);

    always_comb begin
        grant = '0;
        if (start) begin
            grant[pick] = 1'b1;
        end
    end

    bin2bcd_seq #(
        .SCORE_W (SCORE_W)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // any nonzero digit above the display width saturates to all nines
    always_comb begin
        sat        = 1'b0;
        sat_digits = '0;
        for (int i = DIGITS; i < BCD_INT_DIGITS; i++) begin
            sat = sat | (|bcd[i*4 +: 4]);
        end
        for (int i = 0; i < DIGITS; i++) begin
            sat_digits[i*4 +: 4] = sat ? 4'd9 : bcd[i*4 +: 4];
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (|req) state_nx = ARB;
            ARB:  state_nx = found ? CONV : IDLE;
            CONV: if (conv_done) state_nx = HOLD;
            HOLD: if (hold_last) state_nx = (|req) ? ARB : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ptr          <= '0;
            sel          <= '0;
            digits       <= '0;
            overflow     <= 1'b0;
            digits_valid <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                ptr <= pick;
            end
            if (state == CONV && conv_done) begin
                digits       <= sat_digits;
                overflow     <= sat;
                digits_valid <= 1'b1;
                sel          <= ptr;
                hold_cnt     <= '0;
            end else if (state == HOLD && !hold_last) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_score_display_sched.sv
// Scoreboard bench for score_display_sched with a decimal reference model.
module tb_score_display_sched;

    localparam int NUM_REQ = 4;
    localparam int SCORE_W = 20;
    localparam int DIGITS  = 6;
    localparam int HOLD    = 4;
    localparam int LAT     = SCORE_W + 1;
    localparam int PERIOD  = LAT + HOLD;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*SCORE_W-1:0] value;
    logic [NUM_REQ-1:0]         grant;
    logic [1:0]                 sel;
    logic [DIGITS*4-1:0]        digits;
    logic                       digits_valid;
    logic                       overflow;
    logic                       busy;

    always #5 clk = ~clk;

    score_display_sched #(
        .NUM_REQ     (NUM_REQ),
        .SCORE_W     (SCORE_W),
        .DIGITS      (DIGITS),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .value        (value),
        .grant        (grant),
        .sel          (sel),
        .digits       (digits),
        .digits_valid (digits_valid),
        .overflow     (overflow),
        .busy         (busy)
    );

    typedef struct {
        int          due;
        int          src;
        logic [23:0] dig;
        logic        ovf;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    exp_t        sbq[$];
    int          m_ptr = 0;
    logic [23:0] prev_dig = '0;
    logic        prev_ovf = 1'b0;
    int          prev_sel = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // decimal display the spec asks for, saturating above six digits
    function automatic logic [24:0] ref_disp(input int v);
        logic [23:0] d;
        d = '0;
        if (v > 999999) return {1'b1, 24'h999999};
        for (int i = 0; i < 6; i++) begin
            d[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {1'b0, d};
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // monitor: predicts on grant, checks at commit and the cycle before
    always @(negedge clk) begin
        int          e;
        exp_t        x;
        logic [24:0] r;
        if (!reset) begin
            sbq.delete();
            m_ptr    = 0;
            prev_dig = '0;
            prev_ovf = 1'b0;
            prev_sel = 0;
        end else begin
            if (grant != 0) begin
                e = rr_pick(req, m_ptr);
                chk("grant", 32'(grant), (e < 0) ? 32'd0 : (32'd1 << e));
                if (e >= 0) begin
                    m_ptr = e;
                    r     = ref_disp(int'(value[e*SCORE_W +: SCORE_W]));
                    x.due = cyc + LAT;
                    x.src = e;
                    x.dig = r[23:0];
                    x.ovf = r[24];
                    sbq.push_back(x);
                end
            end
            if (sbq.size() > 0) begin
                if (sbq[0].due == cyc + 1) begin
                    chk("no_partial", {5'b0, overflow, sel, digits},
                        {5'b0, prev_ovf, 2'(prev_sel), prev_dig});
                end else if (sbq[0].due == cyc) begin
                    x = sbq.pop_front();
                    chk("commit_digits", 32'(digits), 32'(x.dig));
                    chk("commit_ovf", 32'(overflow), 32'(x.ovf));
                    chk("commit_sel", 32'(sel), 32'(x.src));
                    chk("commit_valid", 32'(digits_valid), 32'd1);
                    prev_dig = x.dig;
                    prev_ovf = x.ovf;
                    prev_sel = x.src;
                end
            end
        end
    end

    task automatic wait_grant(output logic [3:0] g, output int c,
                              input int maxc);
        g = '0;
        c = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (grant != 0) begin
                g = grant;
                c = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL grant_timeout: got none within %0d cycles", maxc);
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: busy still 1 after %0d cycles", maxc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] g;
        logic [3:0] rr_exp [4];
        int         c, cp;
        rr_exp = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
        reset = 1'b0;
        req   = '0;
        value = '0;
        repeat (2) @(negedge clk);
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_valid", 32'(digits_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        step();
        reset = 1'b1;

        value[19:0] = 20'd36493;
        req = 4'b0001;
        wait_grant(g, c, 10);
        chk("single_grant", 32'(g), 32'b0001);
        step();
        req = '0;
        wait_idle(2 * PERIOD);
        chk("single_digits", 32'(digits), 32'h036493);
        chk("single_ovf", 32'(overflow), 32'd0);

        step();
        value[39:20] = 20'd1047564;
        req = 4'b0010;
        wait_grant(g, c, 10);
        chk("sat_grant", 32'(g), 32'b0010);
        step();
        value[39:20] = 20'd499494;
        wait_grant(g, cp, PERIOD + 5);
        chk("sat_regrant_gap", 32'(cp - c), 32'(PERIOD));
        step();
        req = '0;
        wait_idle(2 * PERIOD);
        chk("unsat_digits", 32'(digits), 32'h499494);
        chk("unsat_ovf", 32'(overflow), 32'd0);

        step();
        req = 4'b0101;
        cp = 0;
        for (int i = 0; i < 4; i++) begin
            wait_grant(g, c, PERIOD + 5);
            chk("rr_grant", 32'(g), 32'(rr_exp[i]));
            if (i > 0) chk("rr_gap", 32'(c - cp), 32'(PERIOD));
            cp = c;
        end
        step();
        req = '0;
        wait_idle(2 * PERIOD);

        step();
        value[19:0] = 20'd172;
        req = 4'b0001;
        wait_grant(g, c, 10);
        @(posedge clk);
        step();
        value[19:0] = 20'd2954;
        wait_grant(g, c, PERIOD + 5);
        chk("capture_regrant", 32'(g), 32'b0001);
        step();
        req = '0;
        wait_idle(2 * PERIOD);
        chk("capture_digits", 32'(digits), 32'h002954);

        step();
        value[19:0] = 20'd13;
        req = 4'b0001;
        wait_grant(g, c, 10);
        step();
        req = '0;
        wait_idle(2 * PERIOD);
        repeat (100) begin
            @(negedge clk);
            chk("idle_hold", {6'b0, busy, digits_valid, digits},
                {6'b0, 1'b0, 1'b1, 24'h000013});
        end

        for (int n = 0; n < 25; n++) begin
            step();
            req = 4'($urandom_range(0, 15));
            for (int j = 0; j < NUM_REQ; j++) begin
                value[j*SCORE_W +: SCORE_W] = 20'($urandom_range(0, 1048575));
            end
            repeat ($urandom_range(1, 40)) @(posedge clk);
        end
        step();
        req = '0;
        wait_idle(2 * PERIOD);

        step();
        value[19:0] = 20'd777;
        req = 4'b0001;
        wait_grant(g, c, 10);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        req   = '0;
        #1;
        chk("midconv_digits", 32'(digits), 32'd0);
        chk("midconv_valid", 32'(digits_valid), 32'd0);
        chk("midconv_grant", 32'(grant), 32'd0);
        chk("midconv_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_reset_idle", {7'b0, busy, digits}, 32'd0);
        end
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
